// File: rtl/pipeline_sequencer_if.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer_if
//   Bundles the hazard, memory-handshake and control signals exchanged between
//   the 5-stage pipeline datapath and the pipeline_sequencer.
//
//   Pipeline -> sequencer:
//     id_valid, id_src1, id_src2, id_two_src       ID-stage instruction sources
//     exe_dest, exe_wb_en, exe_mem_r_en            EXE-stage destination / load
//     mem_dest, mem_wb_en                          MEM-stage destination
//     mem_req, sram_ready                          SRAM access handshake
//     branch_taken                                 EXE resolved a taken branch
//   Sequencer -> pipeline:
//     hazard_freeze  hold PC and IF/ID, bubble into EXE
//     pipe_hold      hold PC, IF/ID, ID/EXE, EXE/MEM
//     mem_wb_bubble  insert bubble into MEM/WB
//     flush          clear IF/ID and ID/EXE
//     mem_timeout    sticky SRAM timeout error flag
//     state          00 RUN, 01 MEM_WAIT, 10 ABORT
//
//   master modport: the pipeline datapath side.
//   slave modport : the sequencer side.
// -----------------------------------------------------------------------------
interface pipeline_sequencer_if;
    logic       id_valid;
    logic [3:0] id_src1;
    logic [3:0] id_src2;
    logic       id_two_src;
    logic [3:0] exe_dest;
    logic       exe_wb_en;
    logic       exe_mem_r_en;
    logic [3:0] mem_dest;
    logic       mem_wb_en;
    logic       mem_req;
    logic       sram_ready;
    logic       branch_taken;

    logic       hazard_freeze;
    logic       pipe_hold;
    logic       mem_wb_bubble;
    logic       flush;
    logic       mem_timeout;
    logic [1:0] state;

    modport master (
        output id_valid, id_src1, id_src2, id_two_src,
        output exe_dest, exe_wb_en, exe_mem_r_en,
        output mem_dest, mem_wb_en, mem_req, sram_ready, branch_taken,
        input  hazard_freeze, pipe_hold, mem_wb_bubble, flush, mem_timeout, state
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_two_src,
        input  exe_dest, exe_wb_en, exe_mem_r_en,
        input  mem_dest, mem_wb_en, mem_req, sram_ready, branch_taken,
        output hazard_freeze, pipe_hold, mem_wb_bubble, flush, mem_timeout, state
    );
endinterface

// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
//   Central stall / flush / freeze controller for the IF-ID-EXE-MEM-WB pipeline.
//   Detects RAW hazards against EXE/MEM destinations, sequences multi-cycle
//   SRAM accesses through a wait state with timeout abort, and flushes the
//   front of the pipe on a taken branch. Priority: memory wait > branch flush
//   > data hazard.
//
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous reset, active-low
//     bus       pipeline_sequencer_if.slave (all handshake/control signals)
//     perf_cnt  {mem_wait_cycles, hazard_stall_cycles, flush_count}, 16-bit
//               saturating each; present only when PIPE_PERF_CNT_EN is defined
//
//   Parameters:
//     FORWARDING   1: stall only on load-use from EXE; 0: stall on any EXE/MEM
//                  RAW match
//     MEM_TIMEOUT  max consecutive MEM_WAIT cycles before forced abort
//     CNT_W        wait counter width; must hold MEM_TIMEOUT
//
//   Optional feature macro: PIPE_PERF_CNT_EN
// -----------------------------------------------------------------------------
module pipeline_sequencer #(
    parameter int FORWARDING  = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_sequencer_if.slave  bus
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [47:0]          perf_cnt
`endif
);

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_MEM_WAIT = 2'b01;
    localparam logic [1:0] ST_ABORT    = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    logic             match1, match2, raw;
    logic             hazard_freeze, pipe_hold, mem_wb_bubble, flush;

    // Hazard term per source: with forwarding only a load still in EXE cannot
    // be bypassed; without it any pending EXE/MEM write is a conflict.
    generate
        if (FORWARDING != 0) begin : g_fwd
            assign match1 = bus.exe_wb_en && bus.exe_mem_r_en && (bus.exe_dest == bus.id_src1);
            assign match2 = bus.exe_wb_en && bus.exe_mem_r_en && (bus.exe_dest == bus.id_src2);
        end else begin : g_no_fwd
            assign match1 = (bus.exe_wb_en && (bus.exe_dest == bus.id_src1))
                         || (bus.mem_wb_en && (bus.mem_dest == bus.id_src1));
            assign match2 = (bus.exe_wb_en && (bus.exe_dest == bus.id_src2))
                         || (bus.mem_wb_en && (bus.mem_dest == bus.id_src2));
        end
    endgenerate

    assign raw = bus.id_valid && (match1 || (bus.id_two_src && match2));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can
        // leave a signal unassigned and infer a latch.
        hazard_freeze = 1'b0;
        pipe_hold     = 1'b0;
        mem_wb_bubble = 1'b0;
        flush         = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_d     = timeout_q;

        case (state_q)
            ST_RUN: begin
                if (bus.mem_req && !bus.sram_ready) begin
                    // Hold starts in the request cycle itself, not one late.
                    pipe_hold     = 1'b1;
                    mem_wb_bubble = 1'b1;
                    state_d       = ST_MEM_WAIT;
                    wait_cnt_d    = CNT_W'(1);
                end else if (bus.branch_taken) begin
                    flush = 1'b1;
                end else begin
                    hazard_freeze = raw;
                end
            end

            ST_MEM_WAIT: begin
                // Branches are ignored here: EXE is held, so branch_taken is
                // still presented once the access completes and RUN sees it.
                pipe_hold     = !bus.sram_ready;
                mem_wb_bubble = !bus.sram_ready;
                if (bus.sram_ready) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
                    state_d    = ST_ABORT;
                    timeout_d  = 1'b1;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end

            ST_ABORT: begin
                // Release the pipe and drop the hung access from MEM/WB.
                mem_wb_bubble = 1'b1;
                state_d       = ST_RUN;
            end

            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (!rst) begin
            hazard_freeze = 1'b0;
            pipe_hold     = 1'b0;
            mem_wb_bubble = 1'b0;
            flush         = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.hazard_freeze = hazard_freeze;
    assign bus.pipe_hold     = pipe_hold;
    assign bus.mem_wb_bubble = mem_wb_bubble;
    assign bus.flush         = flush;
    assign bus.mem_timeout   = timeout_q;
    assign bus.state         = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] mem_wait_cycles, hazard_stall_cycles, flush_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_wait_cycles     <= '0;
            hazard_stall_cycles <= '0;
            flush_count         <= '0;
        end else begin
            if (pipe_hold && (mem_wait_cycles != 16'hFFFF))
                mem_wait_cycles <= mem_wait_cycles + 16'd1;
            if (hazard_freeze && (hazard_stall_cycles != 16'hFFFF))
                hazard_stall_cycles <= hazard_stall_cycles + 16'd1;
            if (flush && (flush_count != 16'hFFFF))
                flush_count <= flush_count + 16'd1;
        end
    end

    assign perf_cnt = {mem_wait_cycles, hazard_stall_cycles, flush_count};
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_sequencer
//   Two sequencer instances share one stimulus stream:
//     dut0: FORWARDING=0, MEM_TIMEOUT=3 (short timeout to reach ABORT)
//     dut1: FORWARDING=1, MEM_TIMEOUT=255
//   A behavioural model derived from the stall/flush rules predicts every
//   output each cycle; directed sequences add literal expectations.
//   Optional feature macro: PIPE_PERF_CNT_EN (perf_cnt ports and model).
// -----------------------------------------------------------------------------
module tb_pipeline_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [3:0] id_src1;
        logic [3:0] id_src2;
        logic       id_two_src;
        logic [3:0] exe_dest;
        logic       exe_wb_en;
        logic       exe_mem_r_en;
        logic [3:0] mem_dest;
        logic       mem_wb_en;
        logic       mem_req;
        logic       sram_ready;
        logic       branch_taken;
    } stim_t;

    typedef struct packed {
        logic       hf;
        logic       hold;
        logic       bub;
        logic       flush;
        logic       to;
        logic [1:0] st;
    } out_t;

    stim_t s, cur;
    logic  cmp_en = 1'b0;
    int    n_checks = 0;
    int    n_pass   = 0;

    pipeline_sequencer_if if0();
    pipeline_sequencer_if if1();

`ifdef PIPE_PERF_CNT_EN
    logic [47:0] perf0, perf1;
`endif

    pipeline_sequencer #(.FORWARDING(0), .MEM_TIMEOUT(3), .CNT_W(8)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_cnt (perf0)
`endif
    );

    pipeline_sequencer #(.FORWARDING(1), .MEM_TIMEOUT(255), .CNT_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_cnt (perf1)
`endif
    );

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int m_wait  [2];   // cycles spent waiting on the current access (0 = none)
    bit m_abort [2];
    bit m_to    [2];
    int m_perf  [2][3];

    function automatic int timeout_of(input int k);
        return (k == 0) ? 3 : 255;
    endfunction

    function automatic bit depends(input int k, input logic [3:0] r, input stim_t x);
        if (k == 1) return x.exe_wb_en && x.exe_mem_r_en && (x.exe_dest == r);
        return (x.exe_wb_en && (x.exe_dest == r)) || (x.mem_wb_en && (x.mem_dest == r));
    endfunction

    function automatic out_t model_out(input int k, input stim_t x);
        out_t o;
        bit   raw;
        o = '0;
        raw = x.id_valid && (depends(k, x.id_src1, x) || (x.id_two_src && depends(k, x.id_src2, x)));
        o.to = m_to[k];
        o.st = m_abort[k] ? 2'd2 : ((m_wait[k] > 0) ? 2'd1 : 2'd0);
        if (!x.rst) return o;
        if (m_abort[k]) begin
            o.bub = 1'b1;
        end else if (m_wait[k] > 0) begin
            o.hold = !x.sram_ready;
            o.bub  = !x.sram_ready;
        end else if (x.mem_req && !x.sram_ready) begin
            o.hold = 1'b1;
            o.bub  = 1'b1;
        end else if (x.branch_taken) begin
            o.flush = 1'b1;
        end else begin
            o.hf = raw;
        end
        return o;
    endfunction

    function automatic out_t dut_out(input int k);
        if (k == 0)
            return out_t'({if0.hazard_freeze, if0.pipe_hold, if0.mem_wb_bubble,
                           if0.flush, if0.mem_timeout, if0.state});
        return out_t'({if1.hazard_freeze, if1.pipe_hold, if1.mem_wb_bubble,
                       if1.flush, if1.mem_timeout, if1.state});
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            out_t o;
            o = model_out(k, cur);
            if (!cur.rst) begin
                m_wait[k]  = 0;
                m_abort[k] = 0;
                m_to[k]    = 0;
                for (int j = 0; j < 3; j++) m_perf[k][j] = 0;
            end else begin
                if (o.hold  && m_perf[k][0] < 65535) m_perf[k][0]++;
                if (o.hf    && m_perf[k][1] < 65535) m_perf[k][1]++;
                if (o.flush && m_perf[k][2] < 65535) m_perf[k][2]++;
                if (m_abort[k]) begin
                    m_abort[k] = 0;
                end else if (m_wait[k] > 0) begin
                    if (cur.sram_ready) m_wait[k] = 0;
                    else if (m_wait[k] == timeout_of(k)) begin
                        m_wait[k]  = 0;
                        m_abort[k] = 1;
                        m_to[k]    = 1;
                    end else m_wait[k]++;
                end else if (cur.mem_req && !cur.sram_ready) begin
                    m_wait[k] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++)
                check($sformatf("model_cmp_dut%0d", k), 48'(dut_out(k)), 48'(model_out(k, cur)));
`ifdef PIPE_PERF_CNT_EN
            check("perf_cmp_dut0", perf0, {16'(m_perf[0][0]), 16'(m_perf[0][1]), 16'(m_perf[0][2])});
            check("perf_cmp_dut1", perf1, {16'(m_perf[1][0]), 16'(m_perf[1][1]), 16'(m_perf[1][2])});
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic stim_t idle();
        stim_t x;
        x = '0;
        x.rst = 1'b1;
        x.sram_ready = 1'b1;
        return x;
    endfunction

    task automatic apply();
        rst              = cur.rst;
        if0.id_valid     = cur.id_valid;     if1.id_valid     = cur.id_valid;
        if0.id_src1      = cur.id_src1;      if1.id_src1      = cur.id_src1;
        if0.id_src2      = cur.id_src2;      if1.id_src2      = cur.id_src2;
        if0.id_two_src   = cur.id_two_src;   if1.id_two_src   = cur.id_two_src;
        if0.exe_dest     = cur.exe_dest;     if1.exe_dest     = cur.exe_dest;
        if0.exe_wb_en    = cur.exe_wb_en;    if1.exe_wb_en    = cur.exe_wb_en;
        if0.exe_mem_r_en = cur.exe_mem_r_en; if1.exe_mem_r_en = cur.exe_mem_r_en;
        if0.mem_dest     = cur.mem_dest;     if1.mem_dest     = cur.mem_dest;
        if0.mem_wb_en    = cur.mem_wb_en;    if1.mem_wb_en    = cur.mem_wb_en;
        if0.mem_req      = cur.mem_req;      if1.mem_req      = cur.mem_req;
        if0.sram_ready   = cur.sram_ready;   if1.sram_ready   = cur.sram_ready;
        if0.branch_taken = cur.branch_taken; if1.branch_taken = cur.branch_taken;
    endtask

    // Present s for one cycle; returns #1 after the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        cur = s;
        apply();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int cnt, hold_cnt, wait_cnt, low_left;

        cur = '0;
        apply();
        s = idle();
        s.rst = 1'b0;
        cyc();
        cyc();
        cmp_en = 1'b1;
        check("reset_outputs_dut0", 48'(dut_out(0)), 48'h0);
        check("reset_outputs_dut1", 48'(dut_out(1)), 48'h0);

        // RAW without forwarding: EXE match, then MEM match, then clear.
        s = idle();
        s.id_valid = 1'b1; s.id_src1 = 4'd3; s.exe_dest = 4'd3; s.exe_wb_en = 1'b1;
        cyc();
        check("f0_exe_raw", 48'(if0.hazard_freeze), 48'd1);
        check("f1_exe_nonload_no_stall", 48'(if1.hazard_freeze), 48'd0);
        s.exe_wb_en = 1'b0; s.mem_dest = 4'd3; s.mem_wb_en = 1'b1;
        cyc();
        check("f0_mem_raw", 48'(if0.hazard_freeze), 48'd1);
        s.mem_wb_en = 1'b0;
        cyc();
        check("f0_raw_clear", 48'(if0.hazard_freeze), 48'd0);

        // Load-use with forwarding on src2: one stall cycle; non-load: none.
        for (int pass = 0; pass < 2; pass++) begin
            s = idle();
            s.id_valid = 1'b1; s.id_two_src = 1'b1; s.id_src2 = 4'd5;
            s.exe_dest = 4'd5; s.exe_wb_en = 1'b1; s.exe_mem_r_en = (pass == 0);
            cnt = 0;
            cyc();
            cnt += int'(if1.hazard_freeze);
            s.exe_wb_en = 1'b0; s.exe_mem_r_en = 1'b0; s.mem_dest = 4'd5; s.mem_wb_en = 1'b1;
            cyc();
            cnt += int'(if1.hazard_freeze);
            check(pass == 0 ? "f1_load_use_cycles" : "f1_nonload_cycles",
                  48'(cnt), (pass == 0) ? 48'd1 : 48'd0);
        end

        // SRAM wait: 5 low cycles (RUN + 4 MEM_WAIT) then ready.
        s = idle();
        s.mem_req = 1'b1; s.sram_ready = 1'b0;
        hold_cnt = 0; wait_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            hold_cnt += int'(if1.pipe_hold);
            if (if1.state == 2'b01 && if1.pipe_hold) wait_cnt++;
            if (i == 0) check("f1_hold_in_run_cycle", 48'({if1.state, if1.pipe_hold}), 48'b001);
            if (i == 4) begin
                check("f0_abort_state", 48'(if0.state), 48'd2);
                check("f0_abort_hold_bubble", 48'({if0.pipe_hold, if0.mem_wb_bubble}), 48'b01);
            end
        end
        s.sram_ready = 1'b1;
        cyc();
        check("f1_ready_cycle", 48'({if1.state, if1.pipe_hold, if1.mem_wb_bubble}), 48'b0100);
        check("f1_hold_total", 48'(hold_cnt), 48'd5);
        check("f1_wait_hold_cycles", 48'(wait_cnt), 48'd4);
        s.mem_req = 1'b0;
        cyc();
        check("f1_back_to_run", 48'({if1.state, if1.mem_timeout}), 48'b000);
        check("f0_timeout_set", 48'(if0.mem_timeout), 48'd1);
        repeat (3) cyc();
        check("f0_timeout_sticky", 48'(if0.mem_timeout), 48'd1);

        // Branch beats hazard in RUN.
        s = idle();
        s.id_valid = 1'b1; s.id_src1 = 4'd7; s.exe_dest = 4'd7; s.exe_wb_en = 1'b1;
        s.branch_taken = 1'b1;
        cyc();
        check("f0_branch_over_hazard", 48'({if0.flush, if0.hazard_freeze}), 48'b10);

        // Branch during MEM_WAIT deferred until RUN.
        s = idle();
        s.mem_req = 1'b1; s.sram_ready = 1'b0;
        cyc();
        s.branch_taken = 1'b1;
        cyc();
        check("branch_in_wait_dut0", 48'({if0.state, if0.flush}), 48'b010);
        check("branch_in_wait_dut1", 48'({if1.state, if1.flush}), 48'b010);
        s.sram_ready = 1'b1;
        cyc();
        check("branch_ready_cycle", 48'({if0.flush, if1.flush}), 48'b00);
        s.mem_req = 1'b0;
        cyc();
        check("branch_after_wait", 48'({if0.state, if0.flush, if1.state, if1.flush}), 48'b001001);

        // Reset during MEM_WAIT.
        s = idle();
        s.mem_req = 1'b1; s.sram_ready = 1'b0;
        cyc();
        cyc();
        s.rst = 1'b0;
        cyc();
        check("reset_forces_comb_low",
              48'({if0.pipe_hold, if0.mem_wb_bubble, if1.pipe_hold, if1.mem_wb_bubble}), 48'b0000);
        s = idle();
        cyc();
        check("after_reset_dut0", 48'(dut_out(0)), 48'h0);
        check("after_reset_dut1", 48'(dut_out(1)), 48'h0);
`ifdef PIPE_PERF_CNT_EN
        check("perf_after_reset", {perf0, perf1} != 96'h0 ? 48'd1 : 48'd0, 48'd0);
`endif
        s.mem_req = 1'b1; s.sram_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 4) check("f0_counter_restarted_abort", 48'(if0.state), 48'd2);
        end

        // Randomised traffic.
        low_left = 0;
        for (int n = 0; n < 3000; n++) begin
            s = idle();
            s.rst          = ($urandom_range(0, 99) != 0);
            s.id_valid     = 1'($urandom_range(0, 3) != 0);
            s.id_src1      = 4'($urandom_range(0, 3));
            s.id_src2      = 4'($urandom_range(0, 3));
            s.id_two_src   = 1'($urandom_range(0, 1));
            s.exe_dest     = 4'($urandom_range(0, 3));
            s.exe_wb_en    = 1'($urandom_range(0, 1));
            s.exe_mem_r_en = 1'($urandom_range(0, 1));
            s.mem_dest     = 4'($urandom_range(0, 3));
            s.mem_wb_en    = 1'($urandom_range(0, 1));
            s.mem_req      = ($urandom_range(0, 3) == 0);
            s.branch_taken = ($urandom_range(0, 5) == 0);
            if (low_left > 0) begin
                s.sram_ready = 1'b0;
                low_left--;
            end else begin
                s.sram_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) == 0) low_left = $urandom_range(1, 8);
            end
            cyc();
        end

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
